multicycle_datapath: RTL and testbench

//  Parametrised multicycle successor to the single-cycle 16-bit core: datapath + control FSM in one block.

---
 rtl/multicycle_datapath_pkg.sv | 54 +++++
 rtl/multicycle_datapath_regfile.sv | 31 +++
 rtl/multicycle_datapath.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multicycle core: opcodes, ALU functions, FSM states, field slicers.
package multicycle_datapath_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned REG_AW  = 3;

   localparam logic [3:0] OP_LW   = 4'd0;
   localparam logic [3:0] OP_SW   = 4'd1;
   localparam logic [3:0] OP_R    = 4'd2;
   localparam logic [3:0] OP_ADDI = 4'd3;
   localparam logic [3:0] OP_BEQ  = 4'd4;
   localparam logic [3:0] OP_BNE  = 4'd5;
   localparam logic [3:0] OP_JMP  = 4'd6;
   localparam logic [3:0] OP_HALT = 4'd7;

   localparam logic [2:0] FN_ADD = 3'd0;
   localparam logic [2:0] FN_SUB = 3'd1;
   localparam logic [2:0] FN_AND = 3'd2;
   localparam logic [2:0] FN_OR  = 3'd3;
   localparam logic [2:0] FN_SLT = 3'd4;
   localparam logic [2:0] FN_SLL = 3'd5;
   localparam logic [2:0] FN_SRL = 3'd6;
   localparam logic [2:0] FN_XOR = 3'd7;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   function automatic logic [3:0] f_op(input logic [INSTR_W-1:0] ir);
      return ir[15:12];
   endfunction

   function automatic logic [REG_AW-1:0] f_rs(input logic [INSTR_W-1:0] ir);
      return ir[11:9];
   endfunction

   function automatic logic [REG_AW-1:0] f_rt(input logic [INSTR_W-1:0] ir);
      return ir[8:6];
   endfunction

   function automatic logic [REG_AW-1:0] f_rd(input logic [INSTR_W-1:0] ir);
      return ir[5:3];
   endfunction

   function automatic logic [2:0] f_fn(input logic [INSTR_W-1:0] ir);
      return ir[2:0];
   endfunction

endpackage

// File: rtl/multicycle_datapath_regfile.sv
// Eight-entry register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module mc_regfile
   import multicycle_datapath_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rd_a_c,
   output logic [DATA_W-1:0] rd_b_c,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [DATA_W-1:0] regs [8];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (we && (waddr != REG_AW'(0))) begin
         regs[waddr] <= wdata;
      end
   end

   assign rd_a_c = (raddr_a == REG_AW'(0)) ? '0 : regs[raddr_a];
   assign rd_b_c = (raddr_b == REG_AW'(0)) ? '0 : regs[raddr_b];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle core: control FSM plus datapath sharing one req/ack memory port for fetch and load/store.
module multicycle_datapath
   import multicycle_datapath_pkg::*;
#(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic              illegal
);

   state_t               state;
   logic [INSTR_W-1:0]   ir;
   logic [ADDR_W-1:0]    pc;
   logic [ADDR_W-1:0]    br_target;
   logic [DATA_W-1:0]    a;
   logic [DATA_W-1:0]    b;
   logic [DATA_W-1:0]    alu_out;
   logic [DATA_W-1:0]    mdr;

   logic [3:0]           op;
   logic [DATA_W-1:0]    imm_d;
   logic [ADDR_W-1:0]    imm_br;
   logic [DATA_W-1:0]    rf_a;
   logic [DATA_W-1:0]    rf_b;
   logic [DATA_W-1:0]    alu_res;
   logic [DATA_W-1:0]    addr_sum;
   logic [ADDR_W-1:0]    pc_plus2;
   logic [ADDR_W-1:0]    ctl_next;
   logic                 rf_we;
   logic [REG_AW-1:0]    rf_waddr;
   logic [DATA_W-1:0]    rf_wdata;

   assign op       = f_op(ir);
   assign imm_d    = {{(DATA_W-6){ir[5]}}, ir[5:0]};
   assign imm_br   = {{(ADDR_W-7){ir[5]}}, ir[5:0], 1'b0};
   assign addr_sum = a + imm_d;
   assign pc_plus2 = pc + ADDR_W'(2);
   assign pc_out   = pc;

   mc_regfile #(.DATA_W(DATA_W)) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .raddr_a (f_rs(ir)),
      .raddr_b (f_rt(ir)),
      .rd_a_c  (rf_a),
      .rd_b_c  (rf_b),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata)
   );

   // Write-back: R-type targets rd, LW/ADDI target rt; loads come from MDR.
   assign rf_we    = (state == S_WB);
   assign rf_waddr = (op == OP_R) ? f_rd(ir) : f_rt(ir);
   assign rf_wdata = (op == OP_LW) ? mdr : alu_out;

   always_comb begin
      alu_res = '0;
      case (f_fn(ir))
         FN_ADD:  alu_res = a + b;
         FN_SUB:  alu_res = a - b;
         FN_AND:  alu_res = a & b;
         FN_OR:   alu_res = a | b;
         FN_SLT:  alu_res = DATA_W'($signed(a) < $signed(b));
         FN_SLL:  alu_res = a << b[3:0];
         FN_SRL:  alu_res = a >> b[3:0];
         FN_XOR:  alu_res = a ^ b;
         default: alu_res = '0;
      endcase
   end

   // Control-transfer destination resolved in EXEC; PC already points past the branch.
   always_comb begin
      ctl_next = pc;
      if (op == OP_JMP) begin
         ctl_next = {pc[ADDR_W-1:13], ir[11:0], 1'b0};
      end else if (((op == OP_BEQ) && (a == b)) || ((op == OP_BNE) && (a != b))) begin
         ctl_next = br_target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         ir        <= '0;
         br_target <= '0;
         a         <= '0;
         b         <= '0;
         alu_out   <= '0;
         mdr       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= RESET_PC;
         mem_wdata <= '0;
         halted    <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end else if (mem_ack) begin
                  ir      <= mem_rdata[INSTR_W-1:0];
                  pc      <= pc_plus2;
                  mem_req <= 1'b0;
                  state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               a         <= rf_a;
               b         <= rf_b;
               br_target <= pc + imm_br;
               if ((op == OP_HALT) || op[3]) begin
                  halted  <= 1'b1;
                  illegal <= op[3];
                  state   <= S_HALT;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_LW, OP_SW: begin
                     alu_out   <= addr_sum;
                     mem_req   <= 1'b1;
                     mem_we    <= (op == OP_SW);
                     mem_addr  <= ADDR_W'(addr_sum);
                     mem_wdata <= b;
                     state     <= S_MEM;
                  end
                  OP_R: begin
                     alu_out <= alu_res;
                     state   <= S_WB;
                  end
                  OP_ADDI: begin
                     alu_out <= addr_sum;
                     state   <= S_WB;
                  end
                  OP_BEQ, OP_BNE, OP_JMP: begin
                     pc       <= ctl_next;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= ctl_next;
                     state    <= S_FETCH;
                  end
                  default: begin
                     halted  <= 1'b1;
                     illegal <= 1'b1;
                     state   <= S_HALT;
                  end
               endcase
            end
            S_MEM: begin
               if (mem_req && mem_ack) begin
                  if (mem_we) begin
                     mem_we   <= 1'b0;
                     mem_addr <= pc;
                     state    <= S_FETCH;
                  end else begin
                     mdr     <= mem_rdata;
                     mem_req <= 1'b0;
                     state   <= S_WB;
                  end
               end
            end
            S_WB: begin
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= pc;
               state    <= S_FETCH;
            end
            S_HALT: begin
               mem_req <= 1'b0;
               halted  <= 1'b1;
            end
            default: begin
               mem_req <= 1'b0;
               state   <= S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Program-level bench: memory responder with wait states, store scoreboard and fetch-timing log.
module tb_multicycle_datapath;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 16;

   logic              clk   = 1'b0;
   logic              reset = 1'b1;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic [ADDR_W-1:0] pc_out;
   logic              halted;
   logic              illegal;

   multicycle_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .pc_out    (pc_out),
      .halted    (halted),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } st_t;

   st_t         exp_st [$];
   logic [15:0] mem [0:32767];
   int          fc [int];
   int          cyc       = 0;
   int          total     = 0;
   int          bad       = 0;
   int          data_wait = 0;
   bit          stall     = 1'b0;
   int          pa        = 0;

   logic              busy;
   int                cnt;
   logic [ADDR_W-1:0] h_addr;
   logic              h_we;
   logic [DATA_W-1:0] h_wd;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rt,
                                         input logic [2:0] rs, input int imm);
      logic [5:0] im;
      im = 6'(imm);
      return {op, rs, rt, im};
   endfunction

   function automatic logic [15:0] enc_r(input logic [2:0] rd, input logic [2:0] rs,
                                         input logic [2:0] rt, input logic [2:0] fn);
      return {4'd2, rs, rt, rd, fn};
   endfunction

   function automatic logic [15:0] enc_j(input int tgt);
      logic [11:0] t;
      t = 12'(tgt);
      return {4'd6, t};
   endfunction

   // Data region (bytes 2..0x3F) sees data_wait wait states; code is zero-wait.
   function automatic int wait_for(input logic [ADDR_W-1:0] addr);
      return ((addr >= 16'h0002) && (addr < 16'h0040)) ? data_wait : 0;
   endfunction

   function automatic int dt(input int from_pc, input int to_pc);
      if (fc.exists(from_pc) && fc.exists(to_pc)) return fc[to_pc] - fc[from_pc];
      return -1;
   endfunction

   task automatic clear_prog();
      foreach (mem[i]) mem[i] = 16'h0000;
      exp_st.delete();
      fc.delete();
   endtask

   task automatic org(input int a);
      pa = a;
   endtask

   task automatic put(input logic [15:0] w);
      mem[pa >> 1] = w;
      pa += 2;
   endtask

   task automatic exp_store(input int a, input int d);
      st_t s;
      s.addr = a;
      s.data = d;
      exp_st.push_back(s);
   endtask

   task automatic do_reset();
      @(negedge clk) reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
   endtask

   task automatic run_to_halt(input string tag);
      int n;
      n = 0;
      while (!halted && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_halt"}, 32'(halted), 32'd1);
      chk({tag, "_stores_left"}, 32'(exp_st.size()), 32'd0);
   endtask

   // Memory responder: one access at a time, ack after the programmed wait, scoreboard on stores.
   initial begin : responder
      st_t s;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      busy      = 1'b0;
      cnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!mem_req) begin
            mem_ack = 1'b0;
            busy    = 1'b0;
            cnt     = 0;
         end else begin
            if (!busy || mem_ack) begin
               busy   = 1'b1;
               cnt    = 0;
               h_addr = mem_addr;
               h_we   = mem_we;
               h_wd   = mem_wdata;
            end else begin
               cnt++;
               chk("hold_addr", 32'(mem_addr), 32'(h_addr));
               chk("hold_we", 32'(mem_we), 32'(h_we));
               if (h_we) chk("hold_wdata", 32'(mem_wdata), 32'(h_wd));
            end
            mem_ack   = !stall && (cnt >= wait_for(h_addr));
            mem_rdata = '0;
            if (mem_ack) begin
               if (h_we) begin
                  mem[h_addr[15:1]] = h_wd;
                  if (exp_st.size() == 0) begin
                     chk("store_extra", 32'(h_addr), 32'hFFFF_FFFF);
                  end else begin
                     s = exp_st.pop_front();
                     chk("store_addr", 32'(h_addr), 32'(s.addr));
                     chk("store_data", 32'(h_wd), 32'(s.data));
                  end
               end else begin
                  mem_rdata = mem[h_addr[15:1]];
                  fc[int'(h_addr)] = cyc + 1;
               end
            end
         end
      end
   end

   initial begin
      // Main program: ALU ops, r0 write, BEQ taken, BNE not taken; preceded by a reset during a stalled fetch.
      clear_prog();
      org(16'h0000); put(enc_j(16'h020));
      org(16'h0040);
      put(enc_i(4'd3, 3'd1, 3'd0, 5));
      put(enc_i(4'd3, 3'd2, 3'd0, -3));
      put(enc_r(3'd3, 3'd1, 3'd2, 3'd0));
      put(enc_i(4'd1, 3'd3, 3'd0, 30));  exp_store(30, 16'h0002);
      put(enc_r(3'd5, 3'd2, 3'd1, 3'd4));
      put(enc_i(4'd1, 3'd5, 3'd0, 28));  exp_store(28, 16'h0001);
      put(enc_r(3'd0, 3'd1, 3'd1, 3'd0));
      put(enc_i(4'd1, 3'd0, 3'd0, 26));  exp_store(26, 16'h0000);
      put(enc_i(4'd4, 3'd1, 3'd1, 2));
      put(16'h7000);
      put(16'h7000);
      put(enc_i(4'd5, 3'd1, 3'd1, 2));
      put(enc_r(3'd6, 3'd1, 3'd2, 3'd1));
      put(enc_i(4'd1, 3'd6, 3'd0, 24));  exp_store(24, 16'h0008);
      put(enc_r(3'd7, 3'd1, 3'd2, 3'd7));
      put(enc_i(4'd1, 3'd7, 3'd0, 22));  exp_store(22, 16'hFFF8);
      put(enc_r(3'd7, 3'd2, 3'd1, 3'd6));
      put(enc_i(4'd1, 3'd7, 3'd0, 20));  exp_store(20, 16'h07FF);
      put(enc_r(3'd7, 3'd1, 3'd1, 3'd5));
      put(enc_i(4'd1, 3'd7, 3'd0, 18));  exp_store(18, 16'h00A0);
      put(enc_r(3'd7, 3'd1, 3'd3, 3'd3));
      put(enc_i(4'd1, 3'd7, 3'd0, 16));  exp_store(16, 16'h0007);
      put(enc_r(3'd7, 3'd2, 3'd1, 3'd2));
      put(enc_i(4'd1, 3'd7, 3'd0, 14));  exp_store(14, 16'h0005);
      put(16'h7000);

      data_wait = 0;
      stall     = 1'b1;
      do_reset();
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_pc", 32'(pc_out), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'd0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_req", 32'(mem_req), 32'd0);
      chk("midrst_pc", 32'(pc_out), 32'd0);
      stall = 1'b0;
      @(negedge clk) reset = 1'b0;
      run_to_halt("main");
      chk("main_pc", 32'(pc_out), 32'h72);
      chk("main_illegal", 32'(illegal), 32'd0);
      chk("lat_jmp", 32'(dt(16'h00, 16'h40)), 32'd3);
      chk("lat_addi", 32'(dt(16'h40, 16'h42)), 32'd4);
      chk("lat_sw", 32'(dt(16'h46, 16'h48)), 32'd4);
      chk("lat_beq", 32'(dt(16'h50, 16'h56)), 32'd3);
      chk("lat_bne", 32'(dt(16'h56, 16'h58)), 32'd3);
      chk("beq_skip", 32'(fc.exists(16'h52)), 32'd0);

      // Straight-line ADDI/ADDI/ADD from reset with zero-wait memory.
      clear_prog();
      org(16'h0000);
      put(enc_i(4'd3, 3'd1, 3'd0, 5));
      put(enc_i(4'd3, 3'd2, 3'd0, -3));
      put(enc_r(3'd3, 3'd1, 3'd2, 3'd0));
      put(enc_i(4'd1, 3'd3, 3'd0, 30));  exp_store(30, 16'h0002);
      put(16'h7000);
      do_reset();
      repeat (12) @(posedge clk);
      #1;
      chk("p1_pc12", 32'(pc_out), 32'd6);
      run_to_halt("p1");
      chk("p1_lat_addi", 32'(dt(0, 2)), 32'd4);
      chk("p1_lat_add", 32'(dt(4, 6)), 32'd4);
      chk("p1_pc", 32'(pc_out), 32'hA);

      // Store then load of the same word with two data wait states.
      clear_prog();
      org(16'h0000); put(enc_j(16'h020));
      org(16'h0040);
      put(enc_i(4'd3, 3'd1, 3'd0, 5));
      put(enc_i(4'd1, 3'd1, 3'd0, 4));   exp_store(4, 16'h0005);
      put(enc_i(4'd0, 3'd4, 3'd0, 4));
      put(enc_i(4'd1, 3'd4, 3'd0, 6));   exp_store(6, 16'h0005);
      put(16'h7000);
      data_wait = 2;
      do_reset();
      run_to_halt("p2");
      chk("p2_lat_sw", 32'(dt(16'h42, 16'h44)), 32'd6);
      chk("p2_lat_lw", 32'(dt(16'h44, 16'h46)), 32'd7);
      data_wait = 0;

      // JMP keeps PC[15:13]; HALT then holds the memory port idle.
      clear_prog();
      org(16'h0000); put(enc_j(16'hFFF));
      org(16'h1FFE);
      put(enc_i(4'd3, 3'd1, 3'd0, 7));
      put(enc_j(16'h040));
      org(16'h2080);
      put(enc_i(4'd1, 3'd1, 3'd0, 8));   exp_store(8, 16'h0007);
      put(16'h7000);
      do_reset();
      run_to_halt("p3");
      chk("p3_lat_jmp0", 32'(dt(16'h0000, 16'h1FFE)), 32'd3);
      chk("p3_lat_addi", 32'(dt(16'h1FFE, 16'h2000)), 32'd4);
      chk("p3_lat_jmp", 32'(dt(16'h2000, 16'h2080)), 32'd3);
      chk("p3_pc", 32'(pc_out), 32'h2084);
      chk("p3_illegal", 32'(illegal), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("halt_req", 32'(mem_req), 32'd0);
      end
      chk("halt_stay", 32'(halted), 32'd1);

      // Undefined opcode traps into HALT with the sticky flag; reset clears it.
      clear_prog();
      org(16'h0000);
      put(enc_i(4'd3, 3'd1, 3'd0, 1));
      put(16'hF000);
      do_reset();
      run_to_halt("p4");
      chk("p4_illegal", 32'(illegal), 32'd1);
      chk("p4_pc", 32'(pc_out), 32'd4);
      chk("p4_req", 32'(mem_req), 32'd0);
      do_reset();
      chk("p4_rst_illegal", 32'(illegal), 32'd0);
      chk("p4_rst_halted", 32'(halted), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
